// File: rtl/dmem_ctrl_pkg.sv
// rtl/dmem_ctrl_pkg.sv - shared widths and types for the data-memory copy controller
package dmem_ctrl_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;
    localparam int LW_DEF = 8;

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} dma_state_t;

    typedef logic [AW_DEF-1:0] addr_t;
    typedef logic [DW_DEF-1:0] data_t;

endpackage

// File: rtl/dmem_port_mux.sv
// rtl/dmem_port_mux.sv - combinational core/copy-engine select of the memory port
module dmem_port_mux #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          dma_sel,
    input  logic [AW-1:0] core_rd_addr,
    input  logic [AW-1:0] core_wr_addr,
    input  logic [DW-1:0] core_wr_data,
    input  logic          core_wr_en,
    input  logic [AW-1:0] dma_rd_addr,
    input  logic [AW-1:0] dma_wr_addr,
    input  logic [DW-1:0] dma_wr_data,
    input  logic          dma_wr_en,
    output logic [AW-1:0] mem_rd_addr,
    output logic [AW-1:0] mem_wr_addr,
    output logic [DW-1:0] mem_wr_data,
    output logic          mem_wr_en
);

    assign mem_rd_addr = dma_sel ? dma_rd_addr : core_rd_addr;
    assign mem_wr_addr = dma_sel ? dma_wr_addr : core_wr_addr;
    assign mem_wr_data = dma_sel ? dma_wr_data : core_wr_data;
    assign mem_wr_en   = dma_sel ? dma_wr_en   : core_wr_en;

endmodule

// File: rtl/dmem_copy_ctrl.sv
// rtl/dmem_copy_ctrl.sv - block-copy engine sharing the data memory port, core has priority
module dmem_copy_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          CoreMemReq,
    input  logic [AW-1:0] CoreRdAddr,
    input  logic [AW-1:0] CoreWrAddr,
    input  logic [DW-1:0] CoreWrData,
    input  logic          CoreWrEn,
    output logic [DW-1:0] CoreRdData,
    input  logic          Start,
    input  logic [AW-1:0] SrcBase,
    input  logic [AW-1:0] DstBase,
    input  logic [LW-1:0] Len,
    output logic          Busy,
    output logic          Done,
    output logic [AW-1:0] MemRdAddr,
    output logic [AW-1:0] MemWrAddr,
    output logic [DW-1:0] MemWrData,
    output logic          MemWrEn,
    input  logic [DW-1:0] MemRdData
);

    dma_state_t    state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          dma_sel;
    logic [AW-1:0] dma_rd_addr;
    logic [AW-1:0] dma_wr_addr;

    // Address sums wrap naturally at AW bits.
    assign dma_rd_addr = src_q + AW'(idx_q);
    assign dma_wr_addr = dst_q + AW'(idx_q);
    assign dma_sel     = ((state_q == RD) || (state_q == WR)) && !CoreMemReq;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    src_d   = SrcBase;
                    dst_d   = DstBase;
                    len_d   = Len;
                    idx_d   = '0;
                    state_d = (Len == '0) ? DONE : RD;
                end
            end
            RD: begin
                if (!CoreMemReq) begin
                    hold_d  = MemRdData;
                    state_d = WR;
                end
            end
            WR: begin
                if (!CoreMemReq) begin
                    if (idx_q == len_q - LW'(1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + LW'(1);
                        state_d = RD;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Busy       = busy_q;
    assign Done       = done_q;
    assign CoreRdData = MemRdData;

    dmem_port_mux #(
        .AW (AW),
        .DW (DW)
    ) u_port_mux (
        .dma_sel      (dma_sel),
        .core_rd_addr (CoreRdAddr),
        .core_wr_addr (CoreWrAddr),
        .core_wr_data (CoreWrData),
        .core_wr_en   (CoreWrEn),
        .dma_rd_addr  (dma_rd_addr),
        .dma_wr_addr  (dma_wr_addr),
        .dma_wr_data  (hold_q),
        .dma_wr_en    (state_q == WR),
        .mem_rd_addr  (MemRdAddr),
        .mem_wr_addr  (MemWrAddr),
        .mem_wr_data  (MemWrData),
        .mem_wr_en    (MemWrEn)
    );

endmodule

// File: tb/tb_dmem_copy_ctrl.sv
// tb/tb_dmem_copy_ctrl.sv - self-checking bench for dmem_copy_ctrl
module tb_dmem_copy_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       CoreMemReq;
    logic [7:0] CoreRdAddr;
    logic [7:0] CoreWrAddr;
    logic [7:0] CoreWrData;
    logic       CoreWrEn;
    logic [7:0] CoreRdData;
    logic       Start;
    logic [7:0] SrcBase;
    logic [7:0] DstBase;
    logic [7:0] Len;
    logic       Busy;
    logic       Done;
    logic [7:0] MemRdAddr;
    logic [7:0] MemWrAddr;
    logic [7:0] MemWrData;
    logic       MemWrEn;
    logic [7:0] MemRdData;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    assign MemRdData = mem[MemRdAddr];

    always @(posedge Clk) begin
        if (MemWrEn) mem[MemWrAddr] <= MemWrData;
    end

    dmem_copy_ctrl u_dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .CoreMemReq (CoreMemReq),
        .CoreRdAddr (CoreRdAddr),
        .CoreWrAddr (CoreWrAddr),
        .CoreWrData (CoreWrData),
        .CoreWrEn   (CoreWrEn),
        .CoreRdData (CoreRdData),
        .Start      (Start),
        .SrcBase    (SrcBase),
        .DstBase    (DstBase),
        .Len        (Len),
        .Busy       (Busy),
        .Done       (Done),
        .MemRdAddr  (MemRdAddr),
        .MemWrAddr  (MemWrAddr),
        .MemWrData  (MemWrData),
        .MemWrEn    (MemWrEn),
        .MemRdData  (MemRdData)
    );

    typedef struct {
        logic [7:0] src;
        logic [7:0] dst;
        logic [7:0] len;
        int         mode;      // 0 core idle, 1 core window, 2 random core traffic
        int         rs;
        int         rn;
        logic [7:0] cw_addr;
        logic [7:0] cw_data;
        int         exp_done;
        int         exp_wr;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic ref_copy(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] len);
        logic [7:0] s;
        logic [7:0] d;
        for (int i = 0; i < int'(len); i++) begin
            s = src + 8'(i);
            d = dst + 8'(i);
            ref_mem[d] = ref_mem[s];
        end
    endtask

    task automatic check_mem(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== ref_mem[i]) bad++;
        end
        check(name, bad, 0);
    endtask

    // Drives one copy and predicts its timing: after Start, each cycle the
    // core leaves free advances the copy by one access; 2*len accesses then Done.
    task automatic run_copy(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] len,
                            input int mode, input int rs, input int rn,
                            input logic [7:0] cw_addr, input logic [7:0] cw_data,
                            output int done_n);
        int  prog;
        int  exp_done;
        int  busy_n;
        int  wr_n;
        bit  req;
        Start = 1'b1; SrcBase = src; DstBase = dst; Len = len;
        CoreMemReq = 1'b0; CoreWrEn = 1'b0;
        tick;
        Start = 1'b0; SrcBase = 8'($urandom); DstBase = 8'($urandom); Len = 8'($urandom);
        prog = 0; exp_done = -1; done_n = -1; busy_n = 0; wr_n = 0;
        for (int n = 1; n < 300; n++) begin
            case (mode)
                1:       req = (n >= rs) && (n < rs + rn);
                2:       req = ($urandom_range(0, 2) == 0);
                default: req = 1'b0;
            endcase
            CoreMemReq = req;
            CoreRdAddr = 8'($urandom);
            CoreWrEn   = req && (mode == 1 || $urandom_range(0, 1) == 1);
            CoreWrAddr = (mode == 1) ? cw_addr : (8'hC0 | 8'($urandom_range(0, 63)));
            CoreWrData = (mode == 1) ? cw_data : 8'($urandom);
            if (CoreWrEn) ref_mem[CoreWrAddr] = CoreWrData;
            #1;
            if (exp_done < 0) begin
                if (prog == 2 * int'(len)) exp_done = n;
                else if (!req) prog++;
            end
            if (req) begin
                check("passthru", {MemRdAddr, MemWrAddr, MemWrData, 7'd0, MemWrEn},
                      {CoreRdAddr, CoreWrAddr, CoreWrData, 7'd0, CoreWrEn});
            end
            if (Busy) busy_n++;
            if (MemWrEn && !req) wr_n++;
            if (Done && done_n < 0) done_n = n;
            if (!Busy) break;
            tick;
        end
        tick;
        CoreMemReq = 1'b0; CoreWrEn = 1'b0;
        #1;
        check("done_cycle", done_n, exp_done);
        check("busy_cycles", busy_n, exp_done);
        check("dma_writes", wr_n, int'(len));
        ref_copy(src, dst, len);
    endtask

    initial begin
        int done_n;
        int pulses;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
        end
        mem[8'h00] = 8'h52; mem[8'h01] = 8'h03; mem[8'h02] = 8'hE6; mem[8'h03] = 8'h05;
        mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h40] = 8'h4D;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

        tbl[0] = '{8'h00, 8'h80, 8'd4, 0, 0, 0, 8'h00, 8'h00, 9, 4};
        tbl[1] = '{8'h00, 8'h80, 8'd0, 0, 0, 0, 8'h00, 8'h00, 1, 0};
        tbl[2] = '{8'h00, 8'h80, 8'd4, 1, 1, 3, 8'h10, 8'hAA, 12, 4};
        tbl[3] = '{8'hFE, 8'h20, 8'd4, 0, 0, 0, 8'h00, 8'h00, 9, 4};
        tbl[4] = '{8'h40, 8'h41, 8'd3, 0, 0, 0, 8'h00, 8'h00, 7, 3};

        // Reset with Start high and a core write in flight.
        Reset = 1'b1; Start = 1'b1; SrcBase = 8'h00; DstBase = 8'h80; Len = 8'd4;
        CoreMemReq = 1'b0; CoreRdAddr = 8'h02; CoreWrAddr = 8'hF0; CoreWrData = 8'h5A; CoreWrEn = 1'b1;
        ref_mem[8'hF0] = 8'h5A;
        tick; tick;
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_wr_pass", {MemWrEn, MemWrAddr, MemWrData}, {1'b1, 8'hF0, 8'h5A});
        check("rst_rd_data", CoreRdData, 8'hE6);
        Reset = 1'b0; Start = 1'b0; CoreWrEn = 1'b0;
        tick;
        check("idle_after_rst", {Busy, Done}, 0);
        check_mem("mem_after_rst");

        foreach (tbl[k]) begin
            run_copy(tbl[k].src, tbl[k].dst, tbl[k].len, tbl[k].mode, tbl[k].rs, tbl[k].rn,
                     tbl[k].cw_addr, tbl[k].cw_data, done_n);
            check($sformatf("vec%0d_done", k), done_n, tbl[k].exp_done);
            check_mem($sformatf("vec%0d_mem", k));
        end
        check("dst80", {mem[8'h83], mem[8'h82], mem[8'h81], mem[8'h80]}, 32'h05E60352);
        check("core_wr10", mem[8'h10], 8'hAA);
        check("wrap_dst20", {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]}, 32'h03522211);
        check("overlap41", {mem[8'h43], mem[8'h42], mem[8'h41]}, 24'h4D4D4D);

        // Reset in the middle of an 8-byte copy, after two bytes are written.
        Start = 1'b1; SrcBase = 8'h00; DstBase = 8'h90; Len = 8'd8;
        tick;
        Start = 1'b0;
        pulses = 0;
        for (int n = 1; n <= 4; n++) begin
            Start   = (n == 2);
            SrcBase = 8'h50; DstBase = 8'hB0; Len = 8'd1;
            #1;
            if (n == 4) check("mid_wr_addr", {MemWrEn, MemWrAddr}, {1'b1, 8'h91});
            if (Done) pulses++;
            tick;
        end
        Reset = 1'b1; Start = 1'b1;
        tick;
        Reset = 1'b0; Start = 1'b0;
        check("abort_busy", Busy, 0);
        for (int n = 0; n < 4; n++) begin
            if (Done || Busy) pulses++;
            tick;
        end
        check("abort_no_done", pulses, 0);
        ref_mem[8'h90] = ref_mem[8'h00];
        ref_mem[8'h91] = ref_mem[8'h01];
        check_mem("abort_mem");

        run_copy(8'h60, 8'hA0, 8'd5, 0, 0, 0, 8'h00, 8'h00, done_n);
        check("post_abort_done", done_n, 11);
        check_mem("post_abort_mem");

        for (int k = 0; k < 24; k++) begin
            run_copy(8'($urandom_range(0, 8'hAF)), 8'($urandom_range(0, 8'hAF)),
                     8'($urandom_range(0, 16)), 2, 0, 0, 8'h00, 8'h00, done_n);
            check_mem($sformatf("rand%0d_mem", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_copy_ctrl.md
Name: dmem_copy_ctrl

Overview:
Controller that shares the single 256x8 data memory port between the processor core and a block-copy (DMA) engine.
- Core always has priority; the copy engine uses the port only in cycles the core leaves free.
- Copies Len bytes from SrcBase to DstBase, one read and one write per byte, for test setup and data relocation.
- Sits between the core's memory interface and the data memory (combinational read, synchronous write).

Parameters:
AW, 8, address width (memory depth 2**AW)
DW, 8, data width
LW, 8, length field width (max copy 2**LW-1 bytes)

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
CoreMemReq  in  1  core owns memory port this cycle
CoreRdAddr  in  AW  core read address
CoreWrAddr  in  AW  core write address
CoreWrData  in  DW  core write data
CoreWrEn  in  1  core write enable
CoreRdData  out  DW  read data to core (= MemRdData)
Start  in  1  copy request, sampled only in IDLE
SrcBase  in  AW  copy source base
DstBase  in  AW  copy destination base
Len  in  LW  byte count; 0 = no-op
Busy  out  1  copy in progress
Done  out  1  one-cycle completion pulse
MemRdAddr  out  AW  to memory read address
MemWrAddr  out  AW  to memory write address
MemWrData  out  DW  to memory write data
MemWrEn  out  1  to memory write enable
MemRdData  in  DW  from memory (combinational read)

Behaviour:
- FSM states: IDLE, RD, WR, DONE. Registers: state, src, dst, len, idx (LW bits), hold (DW bits).
- Port mux select: dma_sel = (state==RD || state==WR) && !CoreMemReq.
  - dma_sel=0: memory outputs pass the core inputs through combinationally. This includes IDLE and reset.
  - CoreRdData = MemRdData always.
- IDLE: Start=1 at an edge latches SrcBase/DstBase/Len and clears idx. Next state is RD, or DONE if Len==0. Start is ignored in every other state.
- RD:
  - If CoreMemReq=1: stall (hold state, no DMA access).
  - Else: MemRdAddr=src+idx, MemWrEn=0; hold<=MemRdData at the edge; go to WR.
- WR:
  - If CoreMemReq=1: stall.
  - Else: MemWrAddr=dst+idx, MemWrData=hold, MemWrEn=1.
  - If idx==len-1, go to DONE; else idx++ and go to RD.
- DONE: Done=1 for exactly one cycle, then IDLE.
- Busy=1 in RD, WR, DONE; Busy=0 in IDLE.
- Latency, uncontested:
  - Start edge at cycle t gives Busy=1 from t+1 and Done=1 in cycle t+2N+1.
  - Len=0 gives Done in cycle t+1.
  - Each core-priority cycle during RD/WR adds exactly one cycle.
- Addresses are computed modulo 2**AW; src+idx and dst+idx wrap 0xFF->0x00.
- Overlap: the copy is strictly ascending and bytewise sequential (read byte i, then write byte i, then read byte i+1). Overlapping regions yield exactly that sequential result; no buffering beyond one byte.
- Core writes during a copy land normally. If they hit the source region ahead of idx, the copy sees the new data.
- Reset (at any time, including mid-copy):
  - Next edge: state=IDLE, Busy=0, Done=0, idx=0, hold=0, src/dst/len=0.
  - Bytes already written remain; the rest of the copy is abandoned.
  - Start asserted in the same cycle as Reset is ignored.
- Reset values of outputs: Busy=0, Done=0. Memory outputs follow the core inputs (MemWrEn=CoreWrEn).

Decomposition:
- Package dmem_ctrl_pkg:
  - AW/DW/LW defaults.
  - typedef enum logic[1:0] {IDLE, RD, WR, DONE} dma_state_t.
  - typedef logic[AW-1:0] addr_t and logic[DW-1:0] data_t.
- One natural sub-module: dmem_port_mux (purely combinational core/DMA select of the four memory outputs).
- The FSM, counters and registers stay in dmem_copy_ctrl.

Test Plan:
- Preload mem[0..3]={52,03,E6,05}; Reset; Start Src=00 Dst=80 Len=4, core idle -> Busy high for 9 cycles; Done pulse in cycle t+9; mem[80..83]={52,03,E6,05}; MemWrEn high exactly 4 cycles.
- Start Len=0 -> Done in cycle t+1, Busy high 1 cycle, no MemWrEn from DMA, memory unchanged.
- Copy Src=00 Dst=80 Len=4 with CoreMemReq=1 for 3 cycles during a RD, core writing mem[10]=AA -> core write lands, DMA stalls, Done at t+12, destination correct.
- Src=FE Dst=20 Len=4 with mem[FE,FF,00,01]={11,22,52,03} -> mem[20..23]={11,22,52,03} (read wrap verified).
- Overlap Src=40 Dst=41 Len=3, mem[40]=4D -> mem[41..43]={4D,4D,4D}.
- Start Len=8, assert Start again while Busy (ignored), then Reset after 2 writes -> Busy=0 next edge, only dst+0/dst+1 written, no Done pulse, next Start works normally.
